// File: rtl/vscale_htif_csr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vscale_htif_csr_arbiter_pkg
//   Shared constants for the HTIF/core CSR port arbiter: CSR port widths,
//   CSR command codes, HTIF PCR width, the arbiter FSM encoding and small
//   helper functions used to build host-side commands and responses.
// ---------------------------------------------------------------------------
package vscale_htif_csr_arbiter_pkg;

    // CSR port geometry (matches the core's control constants)
    localparam int CSR_ADDR_WIDTH = 12;
    localparam int CSR_CMD_WIDTH  = 3;
    localparam int XPR_LEN        = 32;
    localparam int HTIF_PCR_WIDTH = 64;

    // CSR command codes
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_IDLE  = 3'd0;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_READ  = 3'd4;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_WRITE = 3'd5;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PEND = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // Host requests only ever read or write the whole register.
    function automatic logic [CSR_CMD_WIDTH-1:0] host_cmd(input logic rw);
        return rw ? CSR_WRITE : CSR_READ;
    endfunction

    // The host sees the pre-access CSR value zero-extended to its PCR width.
    function automatic logic [HTIF_PCR_WIDTH-1:0] zext_resp(input logic [XPR_LEN-1:0] v);
        return {{(HTIF_PCR_WIDTH - XPR_LEN){1'b0}}, v};
    endfunction

endpackage

// File: rtl/vscale_htif_csr_arbiter.sv
// ---------------------------------------------------------------------------
// vscale_htif_csr_arbiter
//   Owns the single access port of the CSR file and shares it between the
//   core pipeline (default owner) and the host HTIF PCR channel. A latched
//   host request is granted as soon as the core leaves the port idle, or
//   after it has waited STARVE_LIMIT busy cycles, in which case the core is
//   stalled for exactly that one cycle.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   core_csr_*            core CSR request (addr/cmd/wdata), read data, stall
//   csr_*                 CSR file port (addr/cmd/wdata out, rdata in)
//   htif_pcr_req_*        host request channel (valid/ready, rw, addr, data)
//   htif_pcr_resp_*       host response channel (valid/ready, data)
// ---------------------------------------------------------------------------
module vscale_htif_csr_arbiter
    import vscale_htif_csr_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    // core side
    input  logic [CSR_ADDR_WIDTH-1:0] core_csr_addr,
    input  logic [CSR_CMD_WIDTH-1:0]  core_csr_cmd,
    input  logic [XPR_LEN-1:0]        core_csr_wdata,
    output logic [XPR_LEN-1:0]        core_csr_rdata,
    output logic                      core_csr_stall,
    // CSR file side
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
    output logic [CSR_CMD_WIDTH-1:0]  csr_cmd,
    output logic [XPR_LEN-1:0]        csr_wdata,
    input  logic [XPR_LEN-1:0]        csr_rdata,
    // host request
    input  logic                      htif_pcr_req_valid,
    output logic                      htif_pcr_req_ready,
    input  logic                      htif_pcr_req_rw,
    input  logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr,
    input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
    // host response
    output logic                      htif_pcr_resp_valid,
    input  logic                      htif_pcr_resp_ready,
    output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data
);

    // The wait counter must be able to hold STARVE_LIMIT itself.
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e                state_r;
    logic [CNT_W-1:0]          wait_cnt_r;
    logic                      host_rw_r;
    logic [CSR_ADDR_WIDTH-1:0] host_addr_r;
    logic [XPR_LEN-1:0]        host_data_r;
    logic [XPR_LEN-1:0]        resp_data_r;
    logic                      req_ready_r;
    logic                      resp_valid_r;

    logic                      core_active_s;
    logic                      starved_s;
    logic                      host_grant_s;

    // Only the low XPR_LEN bits of host write data reach the CSR file.
    logic                      unused_req_data_hi_s;
    assign unused_req_data_hi_s = ^htif_pcr_req_data[HTIF_PCR_WIDTH-1:XPR_LEN];

    // Grant decision and CSR port mux; the core owns the port unless granted.
    always_comb begin
        core_active_s = (core_csr_cmd != CSR_IDLE);
        starved_s     = (wait_cnt_r == CNT_MAX);
        host_grant_s  = (state_r == ARB_PEND) && (!core_active_s || starved_s);

        if (host_grant_s) begin
            csr_addr  = host_addr_r;
            csr_cmd   = host_cmd(host_rw_r);
            csr_wdata = host_data_r;
        end else begin
            csr_addr  = core_csr_addr;
            csr_cmd   = core_csr_cmd;
            csr_wdata = core_csr_wdata;
        end

        // A core command displaced by the host must be retried next cycle.
        core_csr_stall = host_grant_s && core_active_s;
        core_csr_rdata = csr_rdata;
    end

    // Host handshake outputs come straight from their registers.
    always_comb begin
        htif_pcr_req_ready  = req_ready_r;
        htif_pcr_resp_valid = resp_valid_r;
        htif_pcr_resp_data  = zext_resp(resp_data_r);
    end

    // Arbiter FSM: latch request, wait for grant, hold response until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ARB_IDLE;
            wait_cnt_r   <= {CNT_W{1'b0}};
            host_rw_r    <= 1'b0;
            host_addr_r  <= {CSR_ADDR_WIDTH{1'b0}};
            host_data_r  <= {XPR_LEN{1'b0}};
            resp_data_r  <= {XPR_LEN{1'b0}};
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (htif_pcr_req_valid) begin
                        host_rw_r   <= htif_pcr_req_rw;
                        host_addr_r <= htif_pcr_req_addr;
                        host_data_r <= htif_pcr_req_data[XPR_LEN-1:0];
                        wait_cnt_r  <= {CNT_W{1'b0}};
                        req_ready_r <= 1'b0;
                        state_r     <= ARB_PEND;
                    end else begin
                        state_r     <= ARB_IDLE;
                    end
                end
                ARB_PEND: begin
                    if (host_grant_s) begin
                        // Pre-access value: the CSR file applies the write at this edge.
                        resp_data_r  <= csr_rdata;
                        resp_valid_r <= 1'b1;
                        state_r      <= ARB_RESP;
                    end else if (!starved_s) begin
                        wait_cnt_r   <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        wait_cnt_r   <= wait_cnt_r;
                    end
                end
                ARB_RESP: begin
                    if (htif_pcr_resp_ready) begin
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= ARB_IDLE;
                    end else begin
                        state_r      <= ARB_RESP;
                    end
                end
                default: begin
                    state_r      <= ARB_IDLE;
                    wait_cnt_r   <= {CNT_W{1'b0}};
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vscale_htif_csr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vscale_htif_csr_arbiter
//   Directed plus randomized bench for the HTIF/core CSR arbiter. A simple
//   CSR file model sits on the arbiter's CSR port; a transaction-level
//   reference (an associative register image and the grant rule written as
//   min(core busy run, STARVE_LIMIT)) supplies every expected value.
// ---------------------------------------------------------------------------
module tb_vscale_htif_csr_arbiter;
    import vscale_htif_csr_arbiter_pkg::*;

    localparam int LIMIT = 16;

    logic                      clk;
    logic                      reset;
    logic [CSR_ADDR_WIDTH-1:0] core_csr_addr;
    logic [CSR_CMD_WIDTH-1:0]  core_csr_cmd;
    logic [XPR_LEN-1:0]        core_csr_wdata;
    logic [XPR_LEN-1:0]        core_csr_rdata;
    logic                      core_csr_stall;
    logic [CSR_ADDR_WIDTH-1:0] csr_addr;
    logic [CSR_CMD_WIDTH-1:0]  csr_cmd;
    logic [XPR_LEN-1:0]        csr_wdata;
    logic [XPR_LEN-1:0]        csr_rdata;
    logic                      htif_pcr_req_valid;
    logic                      htif_pcr_req_ready;
    logic                      htif_pcr_req_rw;
    logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr;
    logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data;
    logic                      htif_pcr_resp_valid;
    logic                      htif_pcr_resp_ready;
    logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data;

    vscale_htif_csr_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk                 (clk),
        .reset               (reset),
        .core_csr_addr       (core_csr_addr),
        .core_csr_cmd        (core_csr_cmd),
        .core_csr_wdata      (core_csr_wdata),
        .core_csr_rdata      (core_csr_rdata),
        .core_csr_stall      (core_csr_stall),
        .csr_addr            (csr_addr),
        .csr_cmd             (csr_cmd),
        .csr_wdata           (csr_wdata),
        .csr_rdata           (csr_rdata),
        .htif_pcr_req_valid  (htif_pcr_req_valid),
        .htif_pcr_req_ready  (htif_pcr_req_ready),
        .htif_pcr_req_rw     (htif_pcr_req_rw),
        .htif_pcr_req_addr   (htif_pcr_req_addr),
        .htif_pcr_req_data   (htif_pcr_req_data),
        .htif_pcr_resp_valid (htif_pcr_resp_valid),
        .htif_pcr_resp_ready (htif_pcr_resp_ready),
        .htif_pcr_resp_data  (htif_pcr_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file model: combinational read, write at the clock edge.
    logic [XPR_LEN-1:0] csr_mem [4096] = '{default: 32'h0};
    assign csr_rdata = csr_mem[csr_addr];
    always @(posedge clk) begin
        if (csr_cmd == CSR_WRITE) csr_mem[csr_addr] <= csr_wdata;
    end

    // Reference register image (unwritten registers read as zero).
    logic [XPR_LEN-1:0] ref_mem [logic [CSR_ADDR_WIDTH-1:0]];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [XPR_LEN-1:0] ref_rd(input logic [CSR_ADDR_WIDTH-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // mode 0: idle, 1: busy (read or write), 2: any of the three
    task automatic rand_core(input int mode);
        int pick;
        pick = (mode == 0) ? 0 : (mode == 1) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
        core_csr_cmd   = (pick == 0) ? CSR_IDLE : (pick == 1) ? CSR_READ : CSR_WRITE;
        core_csr_addr  = 12'h300 + 12'($urandom_range(0, 7));
        core_csr_wdata = $urandom;
    endtask

    // Port must mirror the core exactly; core writes then land in the image.
    task automatic check_core_path(input string ph);
        chk({ph, " csr_addr"},  64'(csr_addr),  64'(core_csr_addr));
        chk({ph, " csr_cmd"},   64'(csr_cmd),   64'(core_csr_cmd));
        chk({ph, " csr_wdata"}, 64'(csr_wdata), 64'(core_csr_wdata));
        chk({ph, " stall"},     64'(core_csr_stall), 64'h0);
        chk({ph, " core_rdata"}, 64'(core_csr_rdata), 64'(ref_rd(core_csr_addr)));
        if (core_csr_cmd == CSR_WRITE) ref_mem[core_csr_addr] = core_csr_wdata;
    endtask

    task automatic core_write(input logic [CSR_ADDR_WIDTH-1:0] a, input logic [XPR_LEN-1:0] d);
        @(negedge clk);
        core_csr_cmd = CSR_WRITE; core_csr_addr = a; core_csr_wdata = d;
        #1;
        check_core_path("setup");
    endtask

    // Full host transaction; busy_len = number of leading busy core cycles in PEND.
    task automatic host_txn(input logic rw, input logic [CSR_ADDR_WIDTH-1:0] a,
                            input logic [HTIF_PCR_WIDTH-1:0] d, input int busy_len,
                            input int resp_delay);
        logic [XPR_LEN-1:0] exp_resp;
        int g;
        exp_resp = 32'h0;
        g = (busy_len < LIMIT) ? busy_len : LIMIT;
        @(negedge clk);
        htif_pcr_req_valid = 1'b1; htif_pcr_req_rw = rw;
        htif_pcr_req_addr = a; htif_pcr_req_data = d;
        htif_pcr_resp_ready = 1'b0;
        rand_core(2);
        #1;
        chk("accept req_ready", 64'(htif_pcr_req_ready), 64'h1);
        chk("accept resp_valid", 64'(htif_pcr_resp_valid), 64'h0);
        check_core_path("idle");
        for (int k = 0; k <= g; k++) begin
            @(negedge clk);
            htif_pcr_req_valid = 1'b0;
            rand_core((k < busy_len) ? 1 : 0);
            #1;
            if (k < g) begin
                chk("pend req_ready", 64'(htif_pcr_req_ready), 64'h0);
                chk("pend resp_valid", 64'(htif_pcr_resp_valid), 64'h0);
                check_core_path("pend");
            end else begin
                chk("grant csr_addr", 64'(csr_addr), 64'(a));
                chk("grant csr_cmd", 64'(csr_cmd), rw ? 64'(CSR_WRITE) : 64'(CSR_READ));
                chk("grant csr_wdata", 64'(csr_wdata), 64'(d[31:0]));
                chk("grant stall", 64'(core_csr_stall), (k < busy_len) ? 64'h1 : 64'h0);
                exp_resp = ref_rd(a);
                if (rw) ref_mem[a] = d[31:0];
            end
        end
        for (int i = 0; i <= resp_delay; i++) begin
            @(negedge clk);
            rand_core(2);
            htif_pcr_resp_ready = (i == resp_delay);
            #1;
            chk("resp valid", 64'(htif_pcr_resp_valid), 64'h1);
            chk("resp data", htif_pcr_resp_data, {32'h0, exp_resp});
            chk("resp req_ready", 64'(htif_pcr_req_ready), 64'h0);
            check_core_path("resp");
        end
        @(negedge clk);
        htif_pcr_resp_ready = 1'b0;
        rand_core(0);
        #1;
        chk("back idle req_ready", 64'(htif_pcr_req_ready), 64'h1);
        chk("back idle resp_valid", 64'(htif_pcr_resp_valid), 64'h0);
    endtask

    // One reset cycle, then the post-reset outputs.
    task automatic pulse_reset(input string ph);
        @(negedge clk);
        reset = 1'b1;
        htif_pcr_req_valid = 1'b0; htif_pcr_resp_ready = 1'b0;
        core_csr_cmd = CSR_IDLE;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({ph, " req_ready"},  64'(htif_pcr_req_ready), 64'h1);
        chk({ph, " resp_valid"}, 64'(htif_pcr_resp_valid), 64'h0);
        chk({ph, " resp_data"},  htif_pcr_resp_data, 64'h0);
        chk({ph, " stall"},      64'(core_csr_stall), 64'h0);
        check_core_path(ph);
    endtask

    initial begin
        reset = 1'b1;
        core_csr_addr = 12'h0; core_csr_cmd = CSR_IDLE; core_csr_wdata = 32'h0;
        htif_pcr_req_valid = 1'b0; htif_pcr_req_rw = 1'b0;
        htif_pcr_req_addr = 12'h0; htif_pcr_req_data = 64'h0;
        htif_pcr_resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset req_ready", 64'(htif_pcr_req_ready), 64'h1);
        chk("reset resp_valid", 64'(htif_pcr_resp_valid), 64'h0);
        chk("reset resp_data", htif_pcr_resp_data, 64'h0);
        chk("reset stall", 64'(core_csr_stall), 64'h0);
        check_core_path("reset");

        // Host read with idle core: access at N+1, response from N+2.
        core_write(12'h340, 32'h1234_5678);
        host_txn(1'b0, 12'h340, 64'h0, 0, 0);

        // Host write returns the old value; a later read sees the new one.
        core_write(12'h340, 32'h0000_0001);
        host_txn(1'b1, 12'h340, 64'hFFFF_FFFF_DEAD_BEEF, 0, 0);
        host_txn(1'b0, 12'h340, 64'h0, 0, 0);
        chk("csr image 0x340", 64'(csr_mem[12'h340]), 64'hDEAD_BEEF);

        // Core busy every cycle: 16 core cycles, then one stalled grant.
        host_txn(1'b0, 12'h340, 64'h0, 40, 0);
        // Core busy for exactly the limit, and for a short burst.
        host_txn(1'b0, 12'h301, 64'h0, LIMIT, 0);
        host_txn(1'b1, 12'h302, 64'h0000_0000_CAFE_F00D, 3, 1);

        // Response back-pressured for 5 cycles.
        host_txn(1'b0, 12'h340, 64'h0, 0, 5);

        // Undefined CSR reads back as zero.
        host_txn(1'b0, 12'h7C0, 64'h0, 2, 0);

        // Reset while PEND.
        @(negedge clk);
        htif_pcr_req_valid = 1'b1; htif_pcr_req_rw = 1'b0; htif_pcr_req_addr = 12'h340;
        core_csr_cmd = CSR_IDLE;
        @(negedge clk);
        htif_pcr_req_valid = 1'b0;
        core_csr_cmd = CSR_READ; core_csr_addr = 12'h300;
        pulse_reset("rst pend");
        host_txn(1'b0, 12'h340, 64'h0, 40, 0);

        // Reset while RESP.
        @(negedge clk);
        htif_pcr_req_valid = 1'b1; htif_pcr_req_rw = 1'b0; htif_pcr_req_addr = 12'h340;
        core_csr_cmd = CSR_IDLE;
        @(negedge clk);
        htif_pcr_req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("pre-reset resp_valid", 64'(htif_pcr_resp_valid), 64'h1);
        pulse_reset("rst resp");
        host_txn(1'b0, 12'h340, 64'h0, 0, 2);

        // Idle host: core traffic passes straight through.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rand_core(2);
            #1;
            check_core_path("idle stream");
        end

        // Randomized transactions.
        for (int t = 0; t < 12; t++) begin
            logic [CSR_ADDR_WIDTH-1:0] ha;
            ha = ($urandom_range(0, 4) == 0) ? 12'h7C0 : 12'h300 + 12'($urandom_range(0, 7));
            host_txn(1'($urandom_range(0, 1)), ha, {$urandom, $urandom},
                     int'($urandom_range(0, 20)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
